// File: rtl/round_key_sched.sv
// ============================================================================
// Module  : round_key_sched (with key_expand)
// Brief   : AES-128 round-key scheduler; expands a latched key over a settle
//           window, tabulates keys 0..10 and serves one-cycle indexed reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_expand (
  input  logic [127:0] aes_key,
  output logic [127:0] key1,
  output logic [127:0] key2,
  output logic [127:0] key3,
  output logic [127:0] key4,
  output logic [127:0] key5,
  output logic [127:0] key6,
  output logic [127:0] key7,
  output logic [127:0] key8,
  output logic [127:0] key9,
  output logic [127:0] key10
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 by repeated squaring, then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    return rc;
  endfunction

  logic [127:0] rk [0:10];

  assign rk[0] = aes_key;

  generate
    for (genvar r = 1; r <= 10; r++) begin : g_round
      logic [31:0] rot;
      logic [31:0] t;
      logic [31:0] n0, n1, n2, n3;
      assign rot = {rk[r-1][23:0], rk[r-1][31:24]};
      assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                   ^ {rcon(r), 24'h000000};
      assign n0  = rk[r-1][127:96] ^ t;
      assign n1  = rk[r-1][95:64]  ^ n0;
      assign n2  = rk[r-1][63:32]  ^ n1;
      assign n3  = rk[r-1][31:0]   ^ n2;
      assign rk[r] = {n0, n1, n2, n3};
    end
  endgenerate

  assign key1  = rk[1];
  assign key2  = rk[2];
  assign key3  = rk[3];
  assign key4  = rk[4];
  assign key5  = rk[5];
  assign key6  = rk[6];
  assign key7  = rk[7];
  assign key8  = rk[8];
  assign key9  = rk[9];
  assign key10 = rk[10];

endmodule

module round_key_sched #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic         rk_err,
  output logic [7:0]   gen
);

  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, READY} state_t;

  state_t       state;
  state_t       next_state;
  logic         accept;
  logic         serve;
  logic [127:0] key_reg;
  logic [3:0]   settle_cnt;
  logic [3:0]   cap_idx;
  logic [127:0] exp_keys  [0:10];
  logic [127:0] key_table [0:10];

  assign exp_keys[0] = key_reg;

  key_expand u_key_expand (
    .aes_key (key_reg),
    .key1    (exp_keys[1]),
    .key2    (exp_keys[2]),
    .key3    (exp_keys[3]),
    .key4    (exp_keys[4]),
    .key5    (exp_keys[5]),
    .key6    (exp_keys[6]),
    .key7    (exp_keys[7]),
    .key8    (exp_keys[8]),
    .key9    (exp_keys[9]),
    .key10   (exp_keys[10])
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    key_ready  = (state == IDLE) || (state == READY);
    keys_ready = (state == READY);
    accept     = key_valid && key_ready;
    serve      = rk_req && (state == READY);
    case (state)
      IDLE, READY: if (accept) next_state = LOAD;
      LOAD:        if (settle_cnt == 4'd1) next_state = CAPTURE;
      CAPTURE:     if (cap_idx == 4'd10) next_state = READY;
      default:     next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_reg    <= '0;
      settle_cnt <= '0;
      cap_idx    <= '0;
      gen        <= '0;
      rk_valid   <= 1'b0;
      rk_err     <= 1'b0;
      rk_out     <= '0;
    end else begin
      if (accept) begin
        key_reg    <= key_in;
        settle_cnt <= 4'(SETTLE_CYCLES);
        cap_idx    <= '0;
      end else if (state == LOAD) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else if (state == CAPTURE) begin
        cap_idx <= cap_idx + 4'd1;
        if (cap_idx == 4'd10) gen <= gen + 8'd1;
      end

      // Reads see the table as it stood before this edge, so a rekey from
      // READY still answers from the old keys.
      rk_valid <= serve;
      if (serve) begin
        if (rk_idx <= 4'd10) begin
          rk_out <= key_table[rk_idx];
          rk_err <= 1'b0;
        end else begin
          rk_out <= '0;
          rk_err <= 1'b1;
        end
      end else begin
        rk_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && state == CAPTURE) key_table[cap_idx] <= exp_keys[cap_idx];
  end

endmodule

`default_nettype wire

// File: tb/tb_round_key_sched.sv
// ============================================================================
// Module  : tb_round_key_sched
// Brief   : Randomized bench for round_key_sched against a timing-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_round_key_sched;

  localparam int S = 2;

  localparam logic [127:0] K1    = 128'h534f4d452031323820424954204b4559;
  localparam logic [127:0] K1_R1 = 128'he12186f2c110b4cae152fd9ec119b8c7;
  localparam logic [127:0] K1_RA = 128'h3ea222a7987a5f4a38dc254fec19fc49;
  localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         keys_ready;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic         rk_err;
  logic [7:0]   gen;

  always #5 clk = ~clk;

  round_key_sched #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_ready (keys_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_err     (rk_err),
    .gen        (gen)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   m_sbox [0:255];
  bit           m_init = 1'b0;
  int           m_busy = 0;
  bit           m_have = 1'b0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_table [0:10];
  logic [7:0]   m_gen = '0;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;
  logic [127:0] m_out = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [127:0] exp_key(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 1; i <= r; i++) begin
      t = {w[3][23:0], w[3][31:24]};
      t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = gmul(rc, 8'h02);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Model: once accepted, a key keeps the block busy for S+11 cycles, after
  // which the whole expanded table appears at once.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_init  <= 1'b1;
      m_busy  <= 0;
      m_have  <= 1'b0;
      m_gen   <= '0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_out   <= '0;
    end else begin
      m_valid <= rk_req && m_have && (m_busy == 0);
      if (rk_req && m_have && (m_busy == 0)) begin
        if (rk_idx <= 4'd10) begin
          m_out <= m_table[rk_idx];
          m_err <= 1'b0;
        end else begin
          m_out <= '0;
          m_err <= 1'b1;
        end
      end else begin
        m_err <= 1'b0;
      end
      if (key_valid && (m_busy == 0)) begin
        m_busy <= S + 11;
        m_have <= 1'b0;
        m_pend <= key_in;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_have <= 1'b1;
          m_gen  <= m_gen + 8'd1;
          for (int i = 0; i <= 10; i++) m_table[i] <= exp_key(m_pend, i);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    if (m_init) begin
      check("key_ready",  128'(key_ready),  128'(m_busy == 0));
      check("keys_ready", 128'(keys_ready), 128'(m_busy == 0 && m_have));
      check("rk_valid",   128'(rk_valid),   128'(m_valid));
      check("rk_err",     128'(rk_err),     128'(m_err));
      check("gen",        128'(gen),        128'(m_gen));
      check("rk_out",     rk_out,           m_out);
    end
  endtask

  task automatic load(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (keys_ready) break;
      rk_req    = ($urandom % 2) == 1;
      rk_idx    = 4'($urandom);
      key_valid = ($urandom % 4) == 0;
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rk_req    = 1'b0;
    key_valid = 1'b0;
    check("keys_ready_timeout", 128'(keys_ready), 128'(1));
  endtask

  task automatic read_lit(input logic [3:0] idx, input logic [127:0] exp);
    rk_req = 1'b1;
    rk_idx = idx;
    tick();
    rk_req = 1'b0;
    check("lit_rk_valid", 128'(rk_valid), 128'(1));
    check("lit_rk_out", rk_out, exp);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, c;
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      m_sbox[x] = s;
    end

    tick();
    tick();
    reset_n = 1'b1;
    check("sbox_00", 128'(m_sbox[8'h00]), 128'(8'h63));
    check("sbox_53", 128'(m_sbox[8'h53]), 128'(8'hed));
    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_gen", 128'(gen), 128'(0));
    check("rst_rk_out", rk_out, 128'(0));

    // First load: busy window, dropped reads, ignored key during CAPTURE.
    load(K1);
    for (int c = 1; c <= 13; c++) begin
      check("busy_key_ready", 128'(key_ready), 128'(0));
      key_valid = (c == S + 3);
      key_in    = ~K1;
      rk_req    = 1'b1;
      rk_idx    = 4'(c);
      tick();
    end
    key_valid = 1'b0;
    rk_req    = 1'b0;
    check("c14_keys_ready", 128'(keys_ready), 128'(1));
    check("c14_key_ready", 128'(key_ready), 128'(1));
    check("c14_gen", 128'(gen), 128'(1));
    read_lit(4'd0, K1);
    read_lit(4'd1, K1_R1);
    read_lit(4'd10, K1_RA);

    // Illegal indices back to back, then a legal one.
    rk_req = 1'b1;
    rk_idx = 4'd11;
    tick();
    check("idx11_err", 128'(rk_err), 128'(1));
    check("idx11_out", rk_out, 128'(0));
    rk_idx = 4'd15;
    tick();
    check("idx15_err", 128'(rk_err), 128'(1));
    check("idx15_valid", 128'(rk_valid), 128'(1));
    rk_idx = 4'd3;
    tick();
    rk_req = 1'b0;
    check("idx3_err", 128'(rk_err), 128'(0));
    check("idx3_valid", 128'(rk_valid), 128'(1));

    // Rekey to all-zero with a simultaneous read of the old table.
    key_valid = 1'b1;
    key_in    = '0;
    rk_req    = 1'b1;
    rk_idx    = 4'd1;
    tick();
    key_valid = 1'b0;
    rk_req    = 1'b0;
    check("rekey_old_read", rk_out, K1_R1);
    check("rekey_keys_ready", 128'(keys_ready), 128'(0));
    wait_ready();
    check("rekey_gen", 128'(gen), 128'(2));
    read_lit(4'd0, 128'(0));
    read_lit(4'd1, Z_R1);

    // Reset at capture index 5 aborts the expansion.
    load({$urandom, $urandom, $urandom, $urandom});
    repeat (S + 5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rk_req  = 1'b1;
    rk_idx  = 4'd0;
    tick();
    rk_req  = 1'b0;
    check("abort_rk_valid", 128'(rk_valid), 128'(0));
    check("abort_keys_ready", 128'(keys_ready), 128'(0));
    check("abort_gen", 128'(gen), 128'(0));
    load(K1);
    wait_ready();
    check("fresh_gen", 128'(gen), 128'(1));
    read_lit(4'd10, K1_RA);

    // Free-running random traffic, including opportunistic rekeys.
    for (int i = 0; i < 200; i++) begin
      rk_req    = ($urandom % 4) != 0;
      rk_idx    = 4'($urandom);
      key_valid = ($urandom % 16) == 0;
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    key_valid = 1'b0;
    rk_req    = 1'b0;
    wait_ready();

    // 256 complete loads from reset wrap the generation counter.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      load({$urandom, $urandom, $urandom, $urandom});
      wait_ready();
      check("loop_gen", 128'(gen), 128'(n % 256));
      for (int j = 0; j < 2; j++) begin
        rk_req = 1'b1;
        rk_idx = 4'($urandom);
        tick();
      end
      rk_req = 1'b0;
    end
    check("wrap_gen", 128'(gen), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_key_sched.md
# round_key_sched

Sequential controller that owns the combinational `key_expand` block and serves AES-128 round keys to the cipher round datapath. It accepts a 128-bit cipher key over a valid/ready handshake and holds it stable on `key_expand` for a settle window. It then captures round keys 0..10 into an internal 11-entry table, one entry per cycle, and answers indexed round-key reads with one-cycle latency. It sits between the key-load interface and the round sequencer, so the expansion logic becomes a multicycle path off the cipher's critical path.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the latched key is held on `key_expand` before capture begins; legal range 1..15.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `key_in` in 128: cipher key, sampled on handshake.
- `key_valid` in 1: `key_in` valid.
- `key_ready` out 1: block can accept a key.
- `keys_ready` out 1: round-key table is complete and valid.
- `rk_req` in 1: round-key read request.
- `rk_idx` in 4: round index; 0 is the cipher key, 1..10 are `key1`..`key10`.
- `rk_valid` out 1: registered read response strobe.
- `rk_out` out 128: round key for the request.
- `rk_err` out 1: response is for an illegal index (>10).
- `gen` out 8: count of completed expansions, modulo 256.

## Operation
- `key_expand` is instantiated internally. Its `aes_key` input is driven from a 128-bit key register that is loaded only on an accepted handshake.
- States:
  - IDLE: no valid table.
  - LOAD: settle counter running.
  - CAPTURE: 4-bit capture index 0..10.
  - READY: table valid.
- `key_ready` = 1 in IDLE and READY, 0 in LOAD and CAPTURE.
- Handshake: a key is accepted in a cycle with `key_valid & key_ready`.
  - On the next edge the key register loads, the settle counter loads `SETTLE_CYCLES`, and the state goes to LOAD.
  - `key_valid` while `key_ready` is 0 is ignored; the key is not queued.
- LOAD: the counter decrements each cycle. After exactly `SETTLE_CYCLES` LOAD cycles the state goes to CAPTURE with index 0.
- CAPTURE: each cycle, table[index] is written from the matching `key_expand` output (index 0 from the key register) and the index increments. After the write of index 10 the state goes to READY and `gen` increments, wrapping 255 -> 0.
- `keys_ready` = 1 only in READY.
- Reads:
  - A read is served only in READY. `rk_req` in any other state is dropped, with no response and no error.
  - READY with `rk_req`, `rk_idx` <= 10: next cycle `rk_valid`=1, `rk_out`=table[`rk_idx`], `rk_err`=0.
  - READY with `rk_req`, `rk_idx` 11..15: next cycle `rk_valid`=1, `rk_out`=0, `rk_err`=1.
  - With no served request, `rk_valid`=0 and `rk_err`=0 next cycle, and `rk_out` holds its last value.
- Rekey from READY: a key accepted in the same cycle as an `rk_req` still serves the read from the old table (response next cycle). `keys_ready` falls on that same edge. Old table contents are overwritten during CAPTURE.
- Simultaneous handshake and read in IDLE: the key is accepted and the read is dropped.

## Timing
- Reset (`reset_n`=0 at an edge) gives:
  - state IDLE, `key_ready`=1 after the edge, `keys_ready`=0.
  - `rk_valid`=0, `rk_err`=0, `rk_out`=0, `gen`=0, key register = 0.
  - Table contents are not cleared; they are unreachable until the next CAPTURE completes.
- Reset mid-LOAD or mid-CAPTURE aborts to IDLE. The partial table is never exposed, `gen` resets to 0, and a new key is required.
- With the handshake in cycle 0:
  - LOAD occupies cycles 1..S.
  - CAPTURE occupies cycles S+1..S+11.
  - `keys_ready`=1 and `key_ready`=1 from cycle S+12.
  - With S=2, `keys_ready` rises at cycle 14.
- Read latency is exactly 1 cycle, with back-to-back reads at full rate (one per cycle).
- `key_expand` inputs are constant from cycle 1 until the next accepted key.

## Test plan
- Reset then load key 534f4d452031323820424954204b4559 with S=2:
  - `key_ready` is 0 for cycles 1..13 and `keys_ready` rises at cycle 14.
  - `gen`=1.
  - Reads of idx 0 / 1 / 10 give 534f4d452031323820424954204b4559 / e12186f2c110b4cae152fd9ec119b8c7 / 3ea222a7987a5f4a38dc254fec19fc49, each with `rk_valid` one cycle after `rk_req`.
- Read idx 11 and idx 15 in READY -> `rk_valid`=1, `rk_err`=1, `rk_out`=0. Read idx 3 in the following cycle -> `rk_err`=0.
- `rk_req` during LOAD/CAPTURE -> no `rk_valid`. `key_valid` pulsed during CAPTURE with a different key -> ignored; table keys still match the first key.
- In READY, present a new key with all bytes 00 plus an `rk_req` for idx 1 in the same cycle:
  - Response next cycle is e12186f2c110b4cae152fd9ec119b8c7.
  - `keys_ready` drops on the same edge; after re-expansion idx 0 reads 0.
  - `gen`=2.
- Assert `reset_n`=0 at capture index 5, release, then read -> no response, `keys_ready`=0, `gen`=0. A fresh load completes normally.
- Perform 256 loads -> `gen` wraps to 0 on completion of the 256th.
